// File: rtl/traffic_light_pkg.sv
// Shared definitions for the highway / farm-road traffic light controller:
// controller states, lamp codes, parameter defaults and lamp decode helpers.
package traffic_light_pkg;

    // Controller phases, named highway-lamp / farm-lamp
    typedef enum logic [1:0] {
        HGRE_FRED = 2'd0,
        HYEL_FRED = 2'd1,
        HRED_FGRE = 2'd2,
        HRED_FYEL = 2'd3
    } state_t;

    // One-hot lamp codes
    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] RED    = 3'b100;

    // Parameter defaults
    localparam int TICK_DIV_DEFAULT   = 4;
    localparam int YEL_TICKS_DEFAULT  = 3;
    localparam int FGRN_TICKS_DEFAULT = 10;
    localparam int HGRN_MIN_DEFAULT   = 5;

    // Largest of three values; sizes the dwell timer
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Highway lamp shown in a given phase; unknown phases show highway green
    function automatic logic [2:0] highway_lamp(input state_t s);
        case (s)
            HGRE_FRED: return GREEN;
            HYEL_FRED: return YELLOW;
            HRED_FGRE: return RED;
            HRED_FYEL: return RED;
            default:   return GREEN;
        endcase
    endfunction

    // Farm-road lamp shown in a given phase; unknown phases show farm red
    function automatic logic [2:0] farm_lamp(input state_t s);
        case (s)
            HGRE_FRED: return RED;
            HYEL_FRED: return RED;
            HRED_FGRE: return GREEN;
            HRED_FYEL: return YELLOW;
            default:   return RED;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_tick.sv
// Timing tick divider: counts 0..TICK_DIV-1 and flags the last count as a
// one-cycle tick. clr restarts the count so every phase starts on a fresh
// tick boundary.
module tick_gen
    import traffic_light_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q;

    // Free-running divider, wrapped at LAST and restarted on clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr || (count_q == LAST)) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

    assign tick = (count_q == LAST);

endmodule

// File: rtl/traffic_light.sv
// Highway / farm-road traffic light controller. The highway stays green
// until a farm vehicle is seen and a minimum green has elapsed; the farm
// road then gets a fixed green, bracketed by yellow phases on each side.
// All dwells are whole multiples of the tick period.
module traffic_light
    import traffic_light_pkg::*;
#(
    parameter int TICK_DIV   = TICK_DIV_DEFAULT,
    parameter int YEL_TICKS  = YEL_TICKS_DEFAULT,
    parameter int FGRN_TICKS = FGRN_TICKS_DEFAULT,
    parameter int HGRN_MIN   = HGRN_MIN_DEFAULT
) (
    output logic [2:0] light_highway,
    output logic [2:0] light_farm,
    input  logic       sensor,
    input  logic       clk,
    input  logic       rst_n
);

    localparam int            TMAX   = max3(YEL_TICKS, FGRN_TICKS, HGRN_MIN);
    localparam int            TW     = (TMAX < 1) ? 1 : $clog2(TMAX + 1);
    localparam logic [TW-1:0] TMAX_T = TW'(TMAX);
    localparam logic [TW:0]   HMIN_C = (TW + 1)'(HGRN_MIN);
    localparam logic [TW:0]   YEL_C  = (TW + 1)'(YEL_TICKS);
    localparam logic [TW:0]   FGRN_C = (TW + 1)'(FGRN_TICKS);

    logic          sensor_m;
    logic          sensor_s;
    state_t        state_q;
    state_t        state_n;
    logic [TW-1:0] timer_q;
    logic [TW:0]   ticks_done;
    logic          tick;
    logic          advance;

    // Two-flop synchronizer for the asynchronous vehicle sensor
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sensor_m <= 1'b0;
            sensor_s <= 1'b0;
        end else begin
            sensor_m <= sensor;
            sensor_s <= sensor_m;
        end
    end

    // Divider restarts whenever the phase changes
    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (advance),
        .tick (tick)
    );

    // Ticks completed in this phase counting the tick on the current edge,
    // so a dwell of N ticks ends exactly on the N-th tick edge.
    assign ticks_done = {1'b0, timer_q} + {{TW{1'b0}}, tick};

    // Next-phase decision
    always_comb begin
        state_n = state_q;
        case (state_q)
            HGRE_FRED: if (sensor_s && (ticks_done >= HMIN_C))  state_n = HYEL_FRED;
            HYEL_FRED: if (tick && (ticks_done == YEL_C))       state_n = HRED_FGRE;
            HRED_FGRE: if (tick && (ticks_done == FGRN_C))      state_n = HRED_FYEL;
            HRED_FYEL: if (tick && (ticks_done == YEL_C))       state_n = HGRE_FRED;
            default:                                            state_n = HGRE_FRED;
        endcase
    end

    assign advance = (state_n != state_q);

    // Phase register, saturating dwell timer and registered lamp decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HGRE_FRED;
            timer_q       <= '0;
            light_highway <= GREEN;
            light_farm    <= RED;
        end else begin
            state_q       <= state_n;
            light_highway <= highway_lamp(state_n);
            light_farm    <= farm_lamp(state_n);
            if (advance) begin
                timer_q <= '0;
            end else if (tick && (timer_q != TMAX_T)) begin
                timer_q <= timer_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_traffic_light.sv
// Bench for traffic_light: directed phase-timing scenarios plus randomized
// sensor activity, checked cycle by cycle against a dwell-time model.
module tb_traffic_light;
    import traffic_light_pkg::*;

    localparam int DIV  = 4;
    localparam int YEL  = 3;
    localparam int FGRN = 10;
    localparam int HMIN = 5;

    localparam int PH_HG = 0;
    localparam int PH_HY = 1;
    localparam int PH_FG = 2;
    localparam int PH_FY = 3;

    logic       clk;
    logic       rst_n;
    logic       sensor;
    logic [2:0] light_highway;
    logic [2:0] light_farm;

    int         n_checks = 0;
    int         n_errors = 0;
    bit         mon_en   = 1'b0;

    logic [5:0] exp_q[$];
    logic       sens_hist[$];
    int         m_phase;
    int         m_age;

    traffic_light #(
        .TICK_DIV  (DIV),
        .YEL_TICKS (YEL),
        .FGRN_TICKS(FGRN),
        .HGRN_MIN  (HMIN)
    ) dut (
        .light_highway(light_highway),
        .light_farm   (light_farm),
        .sensor       (sensor),
        .clk          (clk),
        .rst_n        (rst_n)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit
    initial begin
        #600000;
        $display("FAIL time_limit: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] phase_lamps(input int ph);
        case (ph)
            PH_HG:   return {GREEN, RED};
            PH_HY:   return {YELLOW, RED};
            PH_FG:   return {RED, GREEN};
            default: return {RED, YELLOW};
        endcase
    endfunction

    function automatic logic legal_code(input logic [2:0] v);
        return (v == GREEN) || (v == YELLOW) || (v == RED);
    endfunction

    // Reference model: phase plus cycles spent in it; sensor seen two edges late
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = PH_HG;
            m_age   = 0;
            sens_hist.delete();
            sens_hist.push_back(1'b0);
            sens_hist.push_back(1'b0);
            exp_q.delete();
        end else begin
            logic s_seen;
            s_seen = sens_hist.pop_front();
            sens_hist.push_back(sensor);
            m_age++;
            case (m_phase)
                PH_HG: if (s_seen && (m_age >= HMIN * DIV)) begin m_phase = PH_HY; m_age = 0; end
                PH_HY: if (m_age == YEL * DIV)              begin m_phase = PH_FG; m_age = 0; end
                PH_FG: if (m_age == FGRN * DIV)             begin m_phase = PH_FY; m_age = 0; end
                default: if (m_age == YEL * DIV)            begin m_phase = PH_HG; m_age = 0; end
            endcase
            exp_q.push_back(phase_lamps(m_phase));
        end
    end

    // Scoreboard: compare lamps mid-cycle against the model
    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst_n) begin
                check("rst_hw", light_highway, GREEN);
                check("rst_fm", light_farm, RED);
            end else if (exp_q.size() > 0) begin
                logic [5:0] e;
                e = exp_q.pop_front();
                check("hw", light_highway, e[5:3]);
                check("fm", light_farm, e[2:0]);
            end
            check("mutex", (light_highway != RED) && (light_farm != RED), 1'b0);
            check("legal", legal_code(light_highway) && legal_code(light_farm), 1'b1);
            assert (light_highway == RED || light_farm == RED)
                else $error("both lamps non-red at t=%0t", $time);
        end
    end

    // Count rising edges until the lamps show hw/fm, bounded by limit
    task automatic wait_for(input logic [2:0] hw, input logic [2:0] fm, input int limit, output int n);
        n = 0;
        while (!(light_highway == hw && light_farm == fm) && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wait_lamps", {light_highway, light_farm}, {hw, fm});
    endtask

    // Pulse reset away from the clock edge and release with the given sensor
    task automatic apply_reset(input logic s);
        @(negedge clk);
        #2 rst_n = 1'b0;
        sensor = s;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Stimulus
    initial begin
        int n;
        rst_n  = 1'b0;
        sensor = 1'b0;
        #1 mon_en = 1'b1;

        // Idle highway: no vehicle, lamps never change
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        check("idle_hw", light_highway, GREEN);
        check("idle_fm", light_farm, RED);

        // Vehicle waiting from reset release, then leaves during yellow
        apply_reset(1'b1);
        wait_for(YELLOW, RED, 100, n);
        check("first_exit", n, HMIN * DIV);
        sensor = 1'b0;
        wait_for(RED, GREEN, 100, n);
        check("hy_len", n, YEL * DIV);
        wait_for(RED, YELLOW, 100, n);
        check("fg_len", n, FGRN * DIV);
        wait_for(GREEN, RED, 100, n);
        check("fy_len", n, YEL * DIV);

        // Late arrival: sensor rises well after minimum green
        apply_reset(1'b0);
        repeat (100) @(negedge clk);
        #2 sensor = 1'b1;
        wait_for(YELLOW, RED, 20, n);
        check("sync_latency", n, 3);

        // Vehicle leaves during farm green: phase keeps its full length
        wait_for(RED, GREEN, 100, n);
        repeat (10) @(posedge clk);
        #1 sensor = 1'b0;
        wait_for(RED, YELLOW, 100, n);
        check("fg_len_drop", n, FGRN * DIV - 10);

        // Continuous demand
        sensor = 1'b1;
        repeat (2400) @(posedge clk);
        #1;
        wait_for(GREEN, RED, 200, n);
        wait_for(YELLOW, RED, 200, n);
        check("hg_len_hold", n, HMIN * DIV);
        wait_for(RED, GREEN, 200, n);
        check("hy_len_hold", n, YEL * DIV);

        // Random sensor activity, including single-cycle pulses
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            #2 sensor = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end

        // Reset during farm green acts immediately and restarts timing
        sensor = 1'b1;
        wait_for(RED, GREEN, 200, n);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_hw", light_highway, GREEN);
        check("async_fm", light_farm, RED);
        @(negedge clk);
        #2 rst_n = 1'b1;
        wait_for(YELLOW, RED, 100, n);
        check("restart", n, HMIN * DIV);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/traffic_light.md
TRAFFIC_LIGHT -- requirements
Module: traffic_light

Interface
REQ-001 Parameter TICK_DIV, default 4: clk cycles per timing tick, legal range 2 or more.
REQ-002 Parameter YEL_TICKS, default 3: dwell of each yellow phase, in ticks.
REQ-003 Parameter FGRN_TICKS, default 10: dwell of farm-road green, in ticks.
REQ-004 Parameter HGRN_MIN, default 5: minimum highway green before yielding, in ticks.
REQ-005 Port list in this positional order: light_highway, light_farm, sensor, clk, rst_n.
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 rst_n  input  1  reset; asynchronous, active-low.
REQ-008 sensor  input  1  farm-road vehicle present; asynchronous to clk.
REQ-009 light_highway  output  3  highway lamp, one-hot: 3'b001 green, 3'b010 yellow, 3'b100 red.
REQ-010 light_farm  output  3  farm-road lamp, same encoding as light_highway.

Function
REQ-011 sensor SHALL pass through a 2-flop synchronizer; only the synchronized value (sensor_s) feeds the FSM.
REQ-012 The FSM SHALL be Moore with four states: HGRE_FRED, HYEL_FRED, HRED_FGRE, HRED_FYEL.
REQ-013 Lamps SHALL decode from the state register only: HGRE_FRED gives 001/100, HYEL_FRED gives 010/100, HRED_FGRE gives 100/001, HRED_FYEL gives 100/010 (highway/farm).
REQ-014 Both lamps SHALL never be non-red at the same time, and no output SHALL take any value other than the three legal codes.
REQ-015 The tick divider SHALL count 0..TICK_DIV-1 and emit a one-cycle tick when the count equals TICK_DIV-1.
REQ-016 Both the divider and the tick timer SHALL clear on every state change, so each state dwell is an exact multiple of TICK_DIV cycles.
REQ-017 The tick timer SHALL increment on each tick and saturate at max(YEL_TICKS, FGRN_TICKS, HGRN_MIN).
REQ-018 HGRE_FRED SHALL go to HYEL_FRED on the first edge where sensor_s is 1 and the timer is at least HGRN_MIN; otherwise it stays.
REQ-019 HYEL_FRED SHALL go to HRED_FGRE on the tick that completes YEL_TICKS ticks; sensor is ignored.
REQ-020 HRED_FGRE SHALL go to HRED_FYEL on the tick that completes FGRN_TICKS ticks; sensor is ignored, and a vehicle leaving does not shorten the phase.
REQ-021 HRED_FYEL SHALL go to HGRE_FRED on the tick that completes YEL_TICKS ticks.
REQ-022 Sensor held high continuously SHALL produce a repeating cycle, with highway green lasting exactly HGRN_MIN ticks each time.
REQ-023 Sensor pulses shorter than 2 clk cycles MAY be missed; the sensor input is not latched.
REQ-024 Unreachable state encodings SHALL recover to HGRE_FRED on the next edge.

Reset
REQ-025 While rst_n is 0: state is HGRE_FRED, timer and divider are 0, synchronizer flops are 0, light_highway is 3'b001, light_farm is 3'b100.
REQ-026 Reset asserted mid-phase (including yellow or farm green) SHALL return the outputs to highway green / farm red immediately, without waiting for a clock edge.
REQ-027 After rst_n rises, the first possible exit from HGRE_FRED is HGRN_MIN*TICK_DIV cycles later.

Structure
REQ-028 The state enum, the lamp codes (RED, YELLOW, GREEN) and the parameter defaults SHALL live in a shared package, traffic_light_pkg.
REQ-029 The tick divider SHALL be one sub-module, tick_gen, with inputs clk, rst_n and clr, and output tick.
REQ-030 The synchronizer and the FSM SHALL be inline in traffic_light.

Verification (default parameters; 12 cycles = 3 ticks)
REQ-031 Reset held, sensor 0 -> lamps 001/100; they remain 001/100 for 300 cycles after release.
REQ-032 Sensor 1 from reset release -> HY 010 at cycle 20, then FG 100/001 for 40 cycles, FY 100/010 for 12 cycles, then highway green again.
REQ-033 Sensor rises at cycle 100 while in HG -> HY appears on the 3rd edge after the rise.
REQ-034 Sensor drops during HY or FG -> the full cycle completes unchanged with durations 12/40/12.
REQ-035 Sensor held high for 2400 cycles -> periodic cycle of HG 20 / HY 12 / FG 40 / FY 12 cycles; the assertion that both lamps are never non-red together holds throughout.
REQ-036 rst_n pulsed low during FG -> 001/100 asynchronously, and the timer restarts from 0.
